// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-DSI bridge: command codes, line geometry
// and the receiver state encoding.
package spi_bridge_pkg;

    localparam int unsigned LINE_BYTES  = 480;
    localparam logic [7:0]  CMD_FRAME   = 8'h3F;
    localparam logic [7:0]  CMD_LINE    = 8'h6B;
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        SKIP
    } rx_state_t;

endpackage

// File: rtl/spi_line_receiver_if.sv
// Line FIFO write port plus framing/error events between the SPI receiver
// (master) and the DSI packetizer (slave).
interface spi_line_receiver_if #(
    parameter int unsigned LINE_BYTES = spi_bridge_pkg::LINE_BYTES
);
    localparam int unsigned CNT_W = $clog2(LINE_BYTES + 1);

    logic             fifo_full_i;
    logic [7:0]       fifo_data_o;
    logic             fifo_wr_o;
    logic             frame_start_o;
    logic             line_start_o;
    logic             line_done_o;
    logic             short_line_o;
    logic             cmd_error_o;
    logic             overflow_o;
    logic [CNT_W-1:0] byte_count_o;

    modport master (
        input  fifo_full_i,
        output fifo_data_o, fifo_wr_o, frame_start_o, line_start_o,
               line_done_o, short_line_o, cmd_error_o, overflow_o, byte_count_o
    );

    modport slave (
        output fifo_full_i,
        input  fifo_data_o, fifo_wr_o, frame_start_o, line_start_o,
               line_done_o, short_line_o, cmd_error_o, overflow_o, byte_count_o
    );

endinterface

// File: rtl/spi_input_sync.sv
// Brings CS/SCK/MOSI into the system clock domain and produces registered
// single-cycle edge events plus the MOSI sample aligned with sck_rise.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = spi_bridge_pkg::SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic spi_cs_i,
    input  logic spi_clk_i,
    input  logic spi_mosi_i,
    output logic sck_rise,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sck_d;

    // NOTE: non-blocking assignments make every flop sample the pre-edge value,
    // which is what turns this into a real shift chain rather than a wire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // CS chain resets low so a CS already low at reset release is not
            // mistaken for a fresh select; a CS rise in IDLE is harmless.
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b0;
            sck_d     <= 1'b0;
            sck_rise  <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            cs_d      <= cs_sync[SYNC_STAGES-1];
            sck_d     <= sck_sync[SYNC_STAGES-1];
            sck_rise  <= sck_sync[SYNC_STAGES-1] & ~sck_d;
            cs_fall   <= cs_d & ~cs_sync[SYNC_STAGES-1];
            cs_rise   <= ~cs_d & cs_sync[SYNC_STAGES-1];
            mosi_s    <= mosi_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_line_receiver.sv
// SPI slave line receiver: deserializes MSB-first bytes, decodes the per-line
// command and writes pixel bytes to the line FIFO with framing/error events.
module spi_line_receiver #(
    parameter int unsigned LINE_BYTES  = spi_bridge_pkg::LINE_BYTES,
    parameter logic [7:0]  CMD_FRAME   = spi_bridge_pkg::CMD_FRAME,
    parameter logic [7:0]  CMD_LINE    = spi_bridge_pkg::CMD_LINE,
    parameter int unsigned SYNC_STAGES = spi_bridge_pkg::SYNC_STAGES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                spi_cs_i,
    input  logic                spi_clk_i,
    input  logic                spi_mosi_i,
    spi_line_receiver_if.master bus
);
    import spi_bridge_pkg::*;

    localparam int unsigned      CNT_W      = $clog2(LINE_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LINE_BYTES);

    logic sck_rise, cs_fall, cs_rise, mosi_s;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock      (clock),
        .reset      (reset),
        .spi_cs_i   (spi_cs_i),
        .spi_clk_i  (spi_clk_i),
        .spi_mosi_i (spi_mosi_i),
        .sck_rise   (sck_rise),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise),
        .mosi_s     (mosi_s)
    );

    rx_state_t        state;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic [7:0]       byte_q;
    logic [7:0]       data_q;
    logic             wr_q, frame_q, line_q, done_q, short_q, err_q, ovf_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count_q + CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            byte_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            frame_q   <= 1'b0;
            line_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            wr_q      <= 1'b0;
            frame_q   <= 1'b0;
            line_q    <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            err_q     <= 1'b0;
            byte_done <= 1'b0;

            // Deserializer runs only while a line is open; CS rise masks a coincident SCK edge.
            if (sck_rise && !cs_rise && (state == CMD || state == DATA)) begin
                shift_q <= {shift_q[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_q    <= {shift_q[6:0], mosi_s};
                end
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= CMD;
                        shift_q <= '0;
                        bit_cnt <= '0;
                        count_q <= '0;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        short_q <= (bit_cnt != 3'd0) || byte_done;
                        state   <= IDLE;
                    end else if (byte_done) begin
                        if (byte_q == CMD_FRAME) begin
                            frame_q <= 1'b1;
                            line_q  <= 1'b1;
                            ovf_q   <= 1'b0;
                            state   <= DATA;
                        end else if (byte_q == CMD_LINE) begin
                            line_q <= 1'b1;
                            state  <= DATA;
                        end else begin
                            err_q <= 1'b1;
                            state <= SKIP;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        short_q <= 1'b1;
                        state   <= IDLE;
                    end else if (byte_done) begin
                        if (bus.fifo_full_i) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wr_q   <= 1'b1;
                            data_q <= byte_q;
                        end
                        count_q <= count_inc;
                        if (count_inc == LAST_COUNT) begin
                            done_q <= 1'b1;
                            state  <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (cs_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_data_o   = data_q;
    assign bus.fifo_wr_o     = wr_q;
    assign bus.frame_start_o = frame_q;
    assign bus.line_start_o  = line_q;
    assign bus.line_done_o   = done_q;
    assign bus.short_line_o  = short_q;
    assign bus.cmd_error_o   = err_q;
    assign bus.overflow_o    = ovf_q;
    assign bus.byte_count_o  = count_q;

endmodule

// File: tb/tb_spi_line_receiver.sv
// Directed bench for spi_line_receiver: drives SPI mode-0 traffic at SCK = clock/4
// and checks writes, framing pulses, counters and byte latency.
module tb_spi_line_receiver;
    import spi_bridge_pkg::*;

    localparam int unsigned LB = 480;

    logic clock = 1'b0;
    logic reset, spi_cs, spi_clk, spi_mosi;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    spi_line_receiver_if #(.LINE_BYTES(LB)) bus ();

    spi_line_receiver #(
        .LINE_BYTES(LB), .CMD_FRAME(8'h3F), .CMD_LINE(8'h6B), .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .spi_cs_i   (spi_cs),
        .spi_clk_i  (spi_clk),
        .spi_mosi_i (spi_mosi),
        .bus        (bus)
    );

    // Event monitor, sampled mid-cycle.
    logic [7:0] wr_log [0:4095];
    int wr_total = 0, frame_total = 0, line_total = 0, done_total = 0;
    int short_total = 0, err_total = 0, wide_total = 0, done_alone = 0;
    logic [5:0] prev_p = '0;

    always @(negedge clock) begin
        logic [5:0] p;
        p = {bus.fifo_wr_o, bus.frame_start_o, bus.line_start_o,
             bus.line_done_o, bus.short_line_o, bus.cmd_error_o};
        if ((p & prev_p) != 6'd0) wide_total++;
        prev_p = p;
        if (bus.fifo_wr_o) begin
            wr_log[wr_total % 4096] = bus.fifo_data_o;
            wr_total++;
        end
        if (bus.frame_start_o) frame_total++;
        if (bus.line_start_o)  line_total++;
        if (bus.short_line_o)  short_total++;
        if (bus.cmd_error_o)   err_total++;
        if (bus.line_done_o) begin
            done_total++;
            if (!bus.fifo_wr_o) done_alone++;
        end
    end

    typedef struct {
        int wr, frame, line, done, shrt, err;
    } snap_t;

    function automatic snap_t take();
        snap_t s;
        s.wr = wr_total; s.frame = frame_total; s.line = line_total;
        s.done = done_total; s.shrt = short_total; s.err = err_total;
        return s;
    endfunction

    function automatic snap_t since(input snap_t s);
        snap_t d;
        d.wr = wr_total - s.wr; d.frame = frame_total - s.frame;
        d.line = line_total - s.line; d.done = done_total - s.done;
        d.shrt = short_total - s.shrt; d.err = err_total - s.err;
        return d;
    endfunction

    // Counts logged writes that differ from the sequence 0,1,2,... (mod 256),
    // with value 'skip' absent from the sequence (-1: nothing skipped).
    function automatic int data_errors(input int base, input int n, input int skip);
        int e = 0;
        int v = 0;
        for (int k = 0; k < n; k++) begin
            if (v == skip) v++;
            if (wr_log[(base + k) % 4096] !== 8'(v)) e++;
            v++;
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            tick(2);
            spi_clk = 1'b1;
            tick(2);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic cs_assert();
        spi_cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_release();
        tick(4);
        spi_cs = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        logic [23:0] outs;
        reset = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        bus.fifo_full_i = 1'b0;
        tick(3);
        outs = {bus.fifo_data_o, bus.fifo_wr_o, bus.frame_start_o, bus.line_start_o,
                bus.line_done_o, bus.short_line_o, bus.cmd_error_o, bus.overflow_o,
                bus.byte_count_o};
        total++; if (outs !== 24'd0) begin bad++; $display("FAIL reset_outputs: got %h want 000000", outs); end
        reset = 1'b0;
        tick(3);
        outs = {bus.fifo_data_o, bus.fifo_wr_o, bus.frame_start_o, bus.line_start_o,
                bus.line_done_o, bus.short_line_o, bus.cmd_error_o, bus.overflow_o,
                bus.byte_count_o};
        total++; if (outs !== 24'd0) begin bad++; $display("FAIL post_reset_outputs: got %h want 000000", outs); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_latency();
        logic [5:0] seen;
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h6B);
        send_bits(8'hA5, 7);
        spi_mosi = 1'b1;
        tick(2);
        spi_clk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            seen[k-1] = bus.fifo_wr_o;
            if (k == 2) spi_clk = 1'b0;
        end
        total++; if (seen !== 6'b010000) begin bad++; $display("FAIL byte_latency: got %b want 010000", seen); end
        total++; if (bus.fifo_data_o !== 8'hA5) begin bad++; $display("FAIL latency_data: got %h want a5", bus.fifo_data_o); end
        total++; if (bus.byte_count_o !== 9'd1) begin bad++; $display("FAIL latency_count: got %0d want 1", bus.byte_count_o); end
        cs_release();
        d = since(s);
        total++; if (d.shrt !== 1) begin bad++; $display("FAIL latency_short: got %0d want 1", d.shrt); end
    endtask

    task automatic test_short_line();
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h6B);
        for (int i = 0; i < 30; i++) send_byte(8'(i));
        cs_release();
        d = since(s);
        total++; if (d.line !== 1 || d.frame !== 0) begin bad++; $display("FAIL short_starts: got line=%0d frame=%0d want 1/0", d.line, d.frame); end
        total++; if (d.wr !== 30) begin bad++; $display("FAIL short_writes: got %0d want 30", d.wr); end
        total++; if (data_errors(s.wr, 30, -1) !== 0) begin bad++; $display("FAIL short_data: got %0d wrong bytes want 0", data_errors(s.wr, 30, -1)); end
        total++; if (d.shrt !== 1 || d.done !== 0) begin bad++; $display("FAIL short_events: got short=%0d done=%0d want 1/0", d.shrt, d.done); end
        total++; if (bus.byte_count_o !== 9'd30) begin bad++; $display("FAIL short_count: got %0d want 30", bus.byte_count_o); end
    endtask

    task automatic test_partial_byte();
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h6B);
        for (int i = 0; i < 3; i++) send_byte(8'(i));
        send_bits(8'hFF, 5);
        cs_release();
        d = since(s);
        total++; if (d.wr !== 3 || data_errors(s.wr, 3, -1) !== 0) begin bad++; $display("FAIL partial_writes: got %0d writes want 3 in order", d.wr); end
        total++; if (d.shrt !== 1) begin bad++; $display("FAIL partial_short: got %0d want 1", d.shrt); end
        total++; if (bus.byte_count_o !== 9'd3) begin bad++; $display("FAIL partial_count: got %0d want 3", bus.byte_count_o); end
    endtask

    task automatic test_bad_command();
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h55);
        for (int i = 0; i < 4; i++) send_byte(8'(i));
        cs_release();
        d = since(s);
        total++; if (d.err !== 1) begin bad++; $display("FAIL badcmd_error: got %0d want 1", d.err); end
        total++; if (d.wr !== 0 || d.line !== 0 || d.shrt !== 0) begin bad++; $display("FAIL badcmd_quiet: got wr=%0d line=%0d short=%0d want 0/0/0", d.wr, d.line, d.shrt); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL badcmd_state: got %0d want %0d", dut.state, IDLE); end
        s = take();
        cs_assert();
        send_byte(8'h6B);
        for (int i = 0; i < 480; i++) send_byte(8'(i));
        cs_release();
        d = since(s);
        total++; if (d.wr !== 480 || data_errors(s.wr, 480, -1) !== 0) begin bad++; $display("FAIL recover_writes: got %0d writes want 480 in order", d.wr); end
        total++; if (d.line !== 1 || d.frame !== 0 || d.done !== 1) begin bad++; $display("FAIL recover_events: got line=%0d frame=%0d done=%0d want 1/0/1", d.line, d.frame, d.done); end
        total++; if (d.err !== 0 || d.shrt !== 0) begin bad++; $display("FAIL recover_errors: got err=%0d short=%0d want 0/0", d.err, d.shrt); end
    endtask

    task automatic test_overflow();
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h6B);
        for (int i = 0; i < 480; i++) begin
            if (i == 9) begin
                bus.fifo_full_i = 1'b1;
                send_byte(8'(i));
                tick(6);
                bus.fifo_full_i = 1'b0;
                total++; if (bus.overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.overflow_o); end
            end else begin
                send_byte(8'(i));
            end
            if (i == 8) begin
                tick(6);
                total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", bus.overflow_o); end
            end
        end
        tick(6);
        d = since(s);
        total++; if (d.wr !== 479 || data_errors(s.wr, 479, 9) !== 0) begin bad++; $display("FAIL ovf_writes: got %0d writes want 479 without byte 10", d.wr); end
        total++; if (bus.byte_count_o !== 9'd480 || d.done !== 1) begin bad++; $display("FAIL ovf_count: got count=%0d done=%0d want 480/1", bus.byte_count_o, d.done); end
        cs_release();
        total++; if (bus.overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o); end
    endtask

    task automatic test_overlength();
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h3F);
        send_byte(8'd0);
        total++; if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow_o); end
        for (int i = 1; i < 485; i++) send_byte(8'(i));
        cs_release();
        d = since(s);
        total++; if (d.wr !== 480 || data_errors(s.wr, 480, -1) !== 0) begin bad++; $display("FAIL overlen_writes: got %0d writes want 480 in order", d.wr); end
        total++; if (d.done !== 1 || d.frame !== 1 || d.shrt !== 0) begin bad++; $display("FAIL overlen_events: got done=%0d frame=%0d short=%0d want 1/1/0", d.done, d.frame, d.shrt); end
        total++; if (bus.byte_count_o !== 9'd480) begin bad++; $display("FAIL overlen_count: got %0d want 480", bus.byte_count_o); end
    endtask

    task automatic test_reset_midline();
        logic [23:0] outs;
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h6B);
        for (int i = 0; i < 199; i++) send_byte(8'(i));
        send_bits(8'd199, 4);
        reset = 1'b1;
        tick(2);
        outs = {bus.fifo_data_o, bus.fifo_wr_o, bus.frame_start_o, bus.line_start_o,
                bus.line_done_o, bus.short_line_o, bus.cmd_error_o, bus.overflow_o,
                bus.byte_count_o};
        total++; if (outs !== 24'd0) begin bad++; $display("FAIL midreset_outputs: got %h want 000000", outs); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL midreset_state: got %0d want %0d", dut.state, IDLE); end
        reset = 1'b0;
        tick(4);
        cs_release();
        d = since(s);
        total++; if (d.shrt !== 0 || d.err !== 0 || d.done !== 0) begin bad++; $display("FAIL midreset_events: got short=%0d err=%0d done=%0d want 0/0/0", d.shrt, d.err, d.done); end
        total++; if (d.wr !== 199) begin bad++; $display("FAIL midreset_writes: got %0d want 199", d.wr); end
        total++; if (bus.byte_count_o !== 9'd0) begin bad++; $display("FAIL midreset_count: got %0d want 0", bus.byte_count_o); end
    endtask

    task automatic test_full_frame();
        snap_t s, d;
        s = take();
        cs_assert();
        send_byte(8'h3F);
        for (int i = 0; i < 480; i++) send_byte(8'(i));
        tick(6);
        total++; if (bus.byte_count_o !== 9'd480) begin bad++; $display("FAIL full_count: got %0d want 480", bus.byte_count_o); end
        cs_release();
        d = since(s);
        total++; if (d.frame !== 1 || d.line !== 1) begin bad++; $display("FAIL full_starts: got frame=%0d line=%0d want 1/1", d.frame, d.line); end
        total++; if (d.wr !== 480) begin bad++; $display("FAIL full_writes: got %0d want 480", d.wr); end
        total++; if (data_errors(s.wr, 480, -1) !== 0) begin bad++; $display("FAIL full_data: got %0d wrong bytes want 0", data_errors(s.wr, 480, -1)); end
        total++; if (d.done !== 1) begin bad++; $display("FAIL full_done: got %0d want 1", d.done); end
        total++; if (d.shrt !== 0 || d.err !== 0 || bus.overflow_o !== 1'b0) begin bad++; $display("FAIL full_errors: got short=%0d err=%0d ovf=%b want 0/0/0", d.shrt, d.err, bus.overflow_o); end
        total++; if (bus.byte_count_o !== 9'd480) begin bad++; $display("FAIL full_count_held: got %0d want 480", bus.byte_count_o); end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_short_line();
        test_partial_byte();
        test_bad_command();
        test_overflow();
        test_overlength();
        test_reset_midline();
        test_full_frame();
        total++; if (wide_total !== 0) begin bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_total); end
        total++; if (done_alone !== 0) begin bad++; $display("FAIL done_alignment: got %0d unaligned line_done want 0", done_alone); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
